// File: rtl/mul4_pkg.sv
// Shared types and constants for the 4x4 multiplier MAC datapath.
package mul4_pkg;

  localparam int unsigned PROD_W    = 8;
  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mul4_accum_ctrl.sv
// Burst sequencer for the accumulator: start/len latch, product counting and
// the product/result handshake strobes.
module mul4_accum_ctrl
  import mul4_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  input  logic             res_ready,
  output logic             prod_ready,
  output logic             res_valid,
  output logic             busy,
  output logic             clr,
  output logic             take
);

  state_t           state, state_nx;
  logic [LEN_W-1:0] cnt, len_q;
  logic             last;

  // Only evaluated in ACCUM, where len_q is never zero.
  assign last = (cnt == len_q - LEN_W'(1));
  assign take = prod_valid & prod_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      if (clr) begin
        cnt   <= '0;
        len_q <= len;
      end else if (take) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    prod_ready = 1'b0;
    res_valid  = 1'b0;
    clr        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid && last) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/mul4_accum.sv
// Accumulate stage of the MAC datapath: sums a burst of 8-bit products into a
// wrapping ACC_W-bit total with a sticky per-burst wrap flag.
module mul4_accum
  import mul4_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  input  logic              res_ready,
  output logic              ovf,
  output logic              busy
);

  logic             clr, take;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic [ACC_W:0]   sum;

  mul4_accum_ctrl #(
    .LEN_W(LEN_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .prod_valid(prod_valid),
    .res_ready (res_ready),
    .prod_ready(prod_ready),
    .res_valid (res_valid),
    .busy      (busy),
    .clr       (clr),
    .take      (take)
  );

  // One extra bit captures the carry out of the accumulator MSB.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (take) begin
      acc <= sum[ACC_W-1:0];
      if (sum[ACC_W]) ovf_q <= 1'b1;
    end
  end

  assign res_data = acc;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_mul4_accum.sv
// Scoreboard bench: two instances (16-bit and 8-bit accumulators) share one
// stimulus stream; expected burst sums come from plain modular arithmetic.
module tb_mul4_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       prod_valid;
  logic [7:0] prod;
  logic       res_ready;

  logic        pr16, rv16, ov16, bz16;
  logic [15:0] rd16;
  logic        pr8, rv8, ov8, bz8;
  logic [7:0]  rd8;

  typedef struct {
    int unsigned data;
    bit          ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mul4_accum #(.ACC_W(16), .LEN_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(pr16),
    .res_valid(rv16), .res_data(rd16), .res_ready(res_ready),
    .ovf(ov16), .busy(bz16)
  );

  mul4_accum #(.ACC_W(8), .LEN_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(pr8),
    .res_valid(rv8), .res_data(rd8), .res_ready(res_ready),
    .ovf(ov8), .busy(bz8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Results are compared every cycle they are presented, so holding
  // res_ready low also checks that data and flag stay put.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rv16 === 1'b1) begin
      if (q16.size() == 0) check("res16_unexpected", 1, 0);
      else begin
        check("res16_data", 64'(rd16), 64'(q16[0].data));
        check("res16_ovf", 64'(ov16), 64'(q16[0].ovf));
        if (res_ready) void'(q16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rv8 === 1'b1) begin
      if (q8.size() == 0) check("res8_unexpected", 1, 0);
      else begin
        check("res8_data", 64'(rd8), 64'(q8[0].data));
        check("res8_ovf", 64'(ov8), 64'(q8[0].ovf));
        if (res_ready) void'(q8.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sum(input int n, input int unsigned p[16]);
    int unsigned s;
    s = 0;
    for (int i = 0; i < n; i++) s += p[i];
    q16.push_back('{data: s % 65536, ovf: (s >= 65536)});
    q8.push_back('{data: s % 256, ovf: (s >= 256)});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out16"}, {59'd0, pr16, rv16, ov16, bz16, |rd16}, 64'd0);
    check({tag, "_out8"},  {59'd0, pr8, rv8, ov8, bz8, |rd8}, 64'd0);
  endtask

  task automatic do_burst(input int n, input int unsigned p[16], input bit bub,
                          input int hold, input bit poke_start);
    expect_sum(n, p);
    start = 1'b1;
    len   = 4'(n);
    tick();
    start = 1'b0;
    check("busy_after_start", {bz16, bz8}, 2'b11);
    for (int i = 0; i < n; i++) begin
      if (bub) begin
        prod_valid = 1'b0;
        prod       = 8'($urandom);
        check("prod_ready_bubble", {pr16, pr8}, 2'b11);
        tick();
      end
      prod_valid = 1'b1;
      prod       = 8'(p[i]);
      check("prod_ready", {pr16, pr8}, 2'b11);
      check("res_valid_early", {rv16, rv8}, 2'b00);
      if (poke_start && i == 0) begin
        start = 1'b1;
        len   = 4'd15;
      end
      tick();
      start = 1'b0;
    end
    prod_valid = 1'b0;
    check("res_valid_after_last", {rv16, rv8}, 2'b11);
    check("prod_ready_in_done", {pr16, pr8}, 2'b00);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("held_in_done", {rv16, rv8, bz16, bz8}, 4'b1111);
    end
    res_ready = 1'b1;
    if (poke_start) begin
      start = 1'b1;
      len   = 4'd3;
    end
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_ack", {rv16, rv8, bz16, bz8}, 4'b0000);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned p[16];
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod_valid = 1'b0;
    prod       = '0;
    res_ready  = 1'b0;
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Abort a len=5 burst after two products; nothing may be emitted.
    start = 1'b1;
    len   = 4'd5;
    tick();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 8'd7;
    tick();
    prod = 8'd8;
    tick();
    prod_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    p = '{default: 0};
    p[0] = 9;
    do_burst(1, p, 1'b0, 0, 1'b0);

    p = '{default: 0};
    p[0] = 15; p[1] = 225; p[2] = 100;
    do_burst(3, p, 1'b0, 0, 1'b0);

    p = '{default: 0};
    p[0] = 1; p[1] = 2; p[2] = 3; p[3] = 4;
    do_burst(4, p, 1'b1, 5, 1'b0);

    p = '{default: 0};
    do_burst(0, p, 1'b0, 1, 1'b0);

    p = '{default: 0};
    p[0] = 200; p[1] = 100;
    do_burst(2, p, 1'b0, 0, 1'b0);
    p = '{default: 0};
    p[0] = 5;
    do_burst(1, p, 1'b0, 0, 1'b0);

    p = '{default: 0};
    p[0] = 11; p[1] = 22;
    do_burst(2, p, 1'b0, 1, 1'b1);
    tick();

    p = '{default: 0};
    for (int i = 0; i < 15; i++) p[i] = 255;
    do_burst(15, p, 1'b0, 0, 1'b0);

    for (int b = 0; b < 30; b++) begin
      int n;
      n = int'($urandom_range(0, 15));
      p = '{default: 0};
      for (int i = 0; i < n; i++) p[i] = $urandom_range(0, 255);
      do_burst(n, p, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    check("queue16_drained", 64'(q16.size()), 64'd0);
    check("queue8_drained", 64'(q8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul4_accum.md
Name: mul4_accum

Overview:
- Downstream consumer of the 4x4 array multiplier. Accepts a burst of 8-bit unsigned products over a valid/ready handshake and accumulates them into a wider running sum.
- Presents the final sum over a second valid/ready handshake.
- Forms the accumulate stage of the small dot-product/MAC datapath built around the combinational array multiplier.

Parameters:
- ACC_W, 16, accumulator and result width in bits; legal range is 8 and up.
- LEN_W, 4, width of the burst-length field; a burst holds 0 to 2^LEN_W-1 products.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a burst; sampled only in IDLE.
- len  in  LEN_W  number of products in the burst; latched when start is accepted.
- prod_valid  in  1  upstream product is valid.
- prod  in  8  unsigned product from the 4x4 array multiplier.
- prod_ready  out  1  block accepts prod this cycle.
- res_valid  out  1  res_data and ovf are valid.
- res_data  out  ACC_W  accumulated sum, modulo 2^ACC_W.
- res_ready  in  1  downstream accepts the result.
- ovf  out  1  sticky flag: accumulator wrapped at least once during this burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert by design convention) forces:
  - state=IDLE, acc=0, cnt=0, len_q=0
  - prod_ready=0, res_valid=0, res_data=0, ovf=0, busy=0
- Reset mid-burst discards the partial sum. No result is emitted.
- State IDLE:
  - prod_ready=0, res_valid=0.
  - On start=1: latch len_q=len, clear acc, cnt and ovf.
    - len!=0: next state ACCUM.
    - len==0: next state DONE, with res_data=0 and ovf=0.
  - Product traffic arriving in IDLE is not accepted; prod_ready stays 0.
- State ACCUM:
  - prod_ready=1 combinationally from the state. It does not depend on prod_valid.
  - Transfer occurs when prod_valid and prod_ready are both 1 on a clock edge. On a transfer:
    - acc <= acc + zero-extended prod, truncated to ACC_W.
    - If the carry out of bit ACC_W-1 is 1, ovf <= 1.
    - cnt <= cnt+1.
  - If a transfer occurs with cnt==len_q-1, the next state is DONE.
  - The first cycle in DONE shows the sum including that last product: one-cycle latency from the last accept to res_valid.
  - Cycles with prod_valid=0 are bubbles. State and acc hold.
  - start is ignored.
- State DONE:
  - res_valid=1, res_data=acc, ovf held, prod_ready=0.
  - res_data and ovf stay stable while res_valid=1 and res_ready=0.
  - On res_ready=1: next state IDLE. res_valid drops the following cycle.
  - start asserted in the same cycle as the res_ready handshake is ignored. The earliest new start is accepted in the cycle after the return to IDLE.
- busy = (state != IDLE).
- Arithmetic: unsigned only; no saturation; wrap modulo 2^ACC_W. ovf is the only overflow indication.
- cnt is LEN_W bits wide and never wraps, because the burst ends at len_q.
- Throughput: one product per cycle in ACCUM. Burst overhead is 1 cycle from start to ACCUM plus 1 cycle in DONE minimum.

Decomposition:
- Shared package mul4_pkg holds:
  - state enum {IDLE, ACCUM, DONE} (2 bits)
  - PROD_W=8
  - default ACC_W and LEN_W constants
- One natural sub-module, mul4_accum_ctrl: the FSM plus cnt/len_q compare, producing prod_ready, res_valid and busy.
- The datapath (acc, ovf) stays in the top module.

Test Plan:
- Reset mid-ACCUM: after 2 of len=5 products, pulse rst_n low → all outputs 0, state IDLE, no res_valid. The next burst len=1, prod=9 → res_data=9.
- Basic burst, len=3, prods 15, 225, 100, back-to-back → prod_ready=1 for 3 cycles. res_valid is asserted the cycle after the 3rd accept, with res_data=340 and ovf=0.
- Bubbles and backpressure, len=4, prods 1, 2, 3, 4 with prod_valid low on alternating cycles; hold res_ready=0 for 5 cycles → res_data=10 stays stable with res_valid=1, and the state returns to IDLE only after res_ready.
- len=0: start → DONE next cycle with res_data=0, ovf=0, and no prod_ready pulse.
- Overflow with ACC_W=8: len=2, prods 200, 100 → res_data=44, ovf=1. A following burst with len=1, prod=5 → res_data=5, ovf=0 (flag cleared per burst).
- Ignored start: pulse start during ACCUM and in the same cycle as the DONE handshake → no re-latch of len. The first new burst begins only from IDLE.
